cyclotron_mem_multi: RTL

Synthesizable multi-channel successor to the single-port DPI memory model behind the Cyclotron LSU path. It has NUM_CHANNELS independent req/resp ports sharing one single-port word-wide storage array, arbitrated round-robin. Reads and writes have fixed LATENCY, and each channel has a credit-protected response FIFO. It is used in FPGA and RTL-only sims where DPI is unavailable, and to stress multi-requester LSU/cache traffic.

---
 rtl/cyclotron_mem_pkg.sv | 22 ++
 rtl/cyclotron_mem_if.sv | 24 ++
 rtl/cyclotron_resp_fifo.sv | 33 +++
 rtl/cyclotron_mem_multi.sv | 86 ++++++++
 4 files changed

// File: rtl/cyclotron_mem_pkg.sv
// cyclotron_mem_pkg: shared configuration, derived widths and pipeline entry type for cyclotron_mem_multi
package cyclotron_mem_pkg;
  localparam int ARCH_LEN = 32;
  localparam int LSU_LANES = 16;
  localparam int TAG_BITS = 32;
  localparam int NUM_CHANNELS = 2;
  localparam int MEM_WORDS = 1024;
  localparam int LATENCY = 2;
  localparam int RESP_DEPTH = 4;
  localparam int DATA_WIDTH = LSU_LANES * ARCH_LEN;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(MASK_WIDTH);
  localparam int IDX_BITS = $clog2(MEM_WORDS);
  localparam int CH_BITS = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int CNT_BITS = $clog2(RESP_DEPTH + 1);
  typedef struct packed {
    logic [CH_BITS-1:0] ch;
    logic store;
    logic [TAG_BITS-1:0] tag;
    logic [DATA_WIDTH-1:0] data;
  } pipe_entry_t;
endpackage

// File: rtl/cyclotron_mem_if.sv
// cyclotron_mem_if: per-channel request/response bus bundle for cyclotron_mem_multi
interface cyclotron_mem_if;
  import cyclotron_mem_pkg::*;
  logic [NUM_CHANNELS-1:0] req_ready;
  logic [NUM_CHANNELS-1:0] req_valid;
  logic [NUM_CHANNELS-1:0] req_store;
  logic [NUM_CHANNELS*ARCH_LEN-1:0] req_address;
  logic [NUM_CHANNELS*TAG_BITS-1:0] req_tag;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] req_data;
  logic [NUM_CHANNELS*MASK_WIDTH-1:0] req_mask;
  logic [NUM_CHANNELS-1:0] resp_ready;
  logic [NUM_CHANNELS-1:0] resp_valid;
  logic [NUM_CHANNELS-1:0] resp_store;
  logic [NUM_CHANNELS*TAG_BITS-1:0] resp_tag;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] resp_data;
  modport master (
    input req_ready, resp_valid, resp_store, resp_tag, resp_data,
    output req_valid, req_store, req_address, req_tag, req_data, req_mask, resp_ready
  );
  modport slave (
    output req_ready, resp_valid, resp_store, resp_tag, resp_data,
    input req_valid, req_store, req_address, req_tag, req_data, req_mask, resp_ready
  );
endinterface

// File: rtl/cyclotron_resp_fifo.sv
// cyclotron_resp_fifo: synchronous power-of-two FIFO with active-low sync reset and show-ahead head
module cyclotron_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad
    $error("cyclotron_resp_fifo: DEPTH must be a power of 2 and >= 2");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + {{AW{1'b0}}, push};
      rp <= rp + {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clock)
    if (push) mem[wp[AW-1:0]] <= din;
  assign dout = mem[rp[AW-1:0]];
  assign empty = wp == rp;
endmodule

// File: rtl/cyclotron_mem_multi.sv
// cyclotron_mem_multi: multi-channel round-robin memory with fixed latency and credited response FIFOs
module cyclotron_mem_multi
  import cyclotron_mem_pkg::*;
(
  input logic clock,
  input logic reset,
  cyclotron_mem_if.slave bus
);
  localparam int RW = 1 + TAG_BITS + DATA_WIDTH;
  if (ARCH_LEN > 32 || TAG_BITS > 32 || RESP_DEPTH < LATENCY || LATENCY < 1) begin : g_bad
    $error("cyclotron_mem_multi: unsupported parameters");
  end
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [CH_BITS-1:0] last_grant, gsel;
  logic [NUM_CHANNELS-1:0] elig, empty, pop, push;
  logic any;
  logic [IDX_BITS-1:0] idx;
  logic [MASK_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] wdata;
  pipe_entry_t ent, out_e;
  logic out_v;
  always_comb begin
    any = 1'b0;
    gsel = last_grant;
    for (int k = 1; k <= NUM_CHANNELS; k++)
      if (!any && elig[(int'(last_grant) + k) % NUM_CHANNELS]) begin
        any = 1'b1;
        gsel = CH_BITS'((int'(last_grant) + k) % NUM_CHANNELS);
      end
  end
  assign bus.req_ready = any ? NUM_CHANNELS'(1) << gsel : '0;
  always_ff @(posedge clock)
    if (!reset) last_grant <= CH_BITS'(NUM_CHANNELS - 1);
    else if (any) last_grant <= gsel;
  assign idx = bus.req_address[int'(gsel)*ARCH_LEN + OFF_BITS +: IDX_BITS];
  always_comb begin
    wdata = bus.req_data[int'(gsel)*DATA_WIDTH +: DATA_WIDTH];
    wmask = bus.req_mask[int'(gsel)*MASK_WIDTH +: MASK_WIDTH];
    ent.ch = gsel;
    ent.store = bus.req_store[gsel];
    ent.tag = bus.req_tag[int'(gsel)*TAG_BITS +: TAG_BITS];
    ent.data = ent.store ? '0 : mem[idx];
  end
  always_ff @(posedge clock)
    if (any && ent.store)
      for (int b = 0; b < MASK_WIDTH; b++)
        if (wmask[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
  if (LATENCY == 1) begin : g_l1
    assign out_e = ent;
    assign out_v = any;
  end else begin : g_ln
    pipe_entry_t pipe [LATENCY-1];
    logic [LATENCY-2:0] pv;
    always_ff @(posedge clock) begin
      pipe[0] <= ent;
      pv[0] <= reset && any;
      for (int s = 1; s < LATENCY - 1; s++) begin
        pipe[s] <= pipe[s-1];
        pv[s] <= reset && pv[s-1];
      end
    end
    assign out_e = pipe[LATENCY-2];
    assign out_v = pv[LATENCY-2];
  end
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [CNT_BITS-1:0] cnt;
    logic [RW-1:0] head;
    assign elig[i] = reset && bus.req_valid[i] && cnt < CNT_BITS'(RESP_DEPTH);
    assign push[i] = out_v && out_e.ch == CH_BITS'(i);
    assign bus.resp_valid[i] = reset && !empty[i];
    assign pop[i] = bus.resp_valid[i] && bus.resp_ready[i];
    assign {bus.resp_store[i], bus.resp_tag[i*TAG_BITS +: TAG_BITS], bus.resp_data[i*DATA_WIDTH +: DATA_WIDTH]} = head;
    always_ff @(posedge clock)
      if (!reset) cnt <= '0;
      else cnt <= cnt + CNT_BITS'(bus.req_ready[i]) - CNT_BITS'(pop[i]);
    cyclotron_resp_fifo #(.WIDTH(RW), .DEPTH(RESP_DEPTH)) u_fifo (
      .clock(clock),
      .reset(reset),
      .push(push[i]),
      .din({out_e.store, out_e.tag, out_e.data}),
      .pop(pop[i]),
      .dout(head),
      .empty(empty[i])
    );
  end
endmodule
